// File: rtl/axi_lite_slave_regs_pkg.sv
// Shared AXI4-Lite definitions for the register slave and its core-side master:
// response codes, bus widths, write-channel states and an index-width helper.
package axi_lite_slave_regs_pkg;

   localparam logic RESP_OKAY   = 1'b0;
   localparam logic RESP_SLVERR = 1'b1;

   localparam int AXI_ADDR_W = 32;
   localparam int AXI_DATA_W = 32;
   localparam int AXI_STRB_W = 4;

   typedef enum logic [1:0] {
      WR_IDLE,
      WR_HAVE_ADDR,
      WR_HAVE_DATA,
      WR_RESP
   } wr_state_e;

   // A single register still needs a 1-bit index so port widths stay legal.
   function automatic int idx_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/axi_lite_reg_bank.sv
// Register storage for the AXI4-Lite slave: byte-strobed writes, flat export,
// one-cycle write pulses and an asynchronous read port.
module axi_lite_reg_bank
   import axi_lite_slave_regs_pkg::*;
#(
   parameter int NUM_REGS = 8,
   parameter int IDX_W    = 3
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     we,
   input  logic [IDX_W-1:0]         wr_idx,
   input  logic [AXI_STRB_W-1:0]    wr_strb,
   input  logic [AXI_DATA_W-1:0]    wr_data,
   input  logic [IDX_W-1:0]         rd_idx,
   output logic [AXI_DATA_W-1:0]    rd_data,
   output logic [NUM_REGS*32-1:0]   reg_bank,
   output logic [NUM_REGS-1:0]      wr_pulse
);

   logic [NUM_REGS-1:0] wr_pulse_reg;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
         logic [31:0] word_reg;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               word_reg <= '0;
            end else if (we && (wr_idx == IDX_W'(gi))) begin
               for (int b = 0; b < AXI_STRB_W; b++) begin
                  if (wr_strb[b]) begin
                     word_reg[8*b +: 8] <= wr_data[8*b +: 8];
                  end
               end
            end
         end

         assign reg_bank[32*gi +: 32] = word_reg;
      end
   endgenerate

   // Pulse lands the cycle after the write, even for an all-zero strobe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_pulse_reg <= '0;
      end else begin
         wr_pulse_reg <= we ? (NUM_REGS'(1) << wr_idx) : '0;
      end
   end

   assign wr_pulse = wr_pulse_reg;
   assign rd_data  = (32'(rd_idx) < 32'(NUM_REGS)) ? reg_bank[32*rd_idx +: 32] : '0;

endmodule

// File: rtl/axi_lite_slave_regs.sv
// AXI4-Lite register slave: independent AW/W capture, one outstanding write, registered reads.
// Define AXI_SLV_DECERR_EN to answer out-of-range accesses with SLVERR instead of OKAY.
module axi_lite_slave_regs
   import axi_lite_slave_regs_pkg::*;
#(
   parameter int          NUM_REGS  = 8,
   parameter logic [31:0] BASE_ADDR = 32'h2000_0000
) (
   input  logic                   axi_aclk_i,
   input  logic                   axi_areset_i,
   input  logic [AXI_ADDR_W-1:0]  axi_araddr_i,
   input  logic                   axi_arvalid_i,
   output logic                   axi_arready_o,
   output logic [AXI_DATA_W-1:0]  axi_rdata_o,
   output logic                   axi_rresp_o,
   output logic                   axi_rvalid_o,
   input  logic                   axi_rready_i,
   input  logic [AXI_ADDR_W-1:0]  axi_awaddr_i,
   input  logic                   axi_awvalid_i,
   output logic                   axi_awready_o,
   input  logic [AXI_DATA_W-1:0]  axi_wdata_i,
   input  logic [AXI_STRB_W-1:0]  axi_wstrb_i,
   input  logic                   axi_wvalid_i,
   output logic                   axi_wready_o,
   output logic                   axi_bresp_o,
   output logic                   axi_bvalid_o,
   input  logic                   axi_bready_i,
   output logic [NUM_REGS*32-1:0] reg_bank_o,
   output logic [NUM_REGS-1:0]    wr_pulse_o
);

   localparam int IDX_W = idx_width(NUM_REGS);

   function automatic logic addr_hit(input logic [31:0] addr);
      logic [31:0] off;
      off = addr - BASE_ADDR;
      return (addr >= BASE_ADDR) && ({2'b00, off[31:2]} < 32'(NUM_REGS));
   endfunction

   function automatic logic [IDX_W-1:0] addr_idx(input logic [31:0] addr);
      return IDX_W'((addr - BASE_ADDR) >> 2);
   endfunction

   wr_state_e             wr_state_reg, wr_state_next;
   logic [31:0]           aw_addr_reg;
   logic [31:0]           w_data_reg;
   logic [3:0]            w_strb_reg;
   logic                  wr_commit;
   logic                  aw_fire, w_fire;
   logic [31:0]           wr_addr;
   logic [31:0]           wr_data;
   logic [3:0]            wr_strb;
   logic                  wr_hit;

   logic                  rvalid_reg;
   logic [31:0]           rdata_reg;
   logic                  ar_fire;
   logic                  rd_hit;
   logic [31:0]           bank_rd_data;

   // Readies decode from state only; reset forces them low.
   assign axi_awready_o = !axi_areset_i &&
                          ((wr_state_reg == WR_IDLE) || (wr_state_reg == WR_HAVE_DATA));
   assign axi_wready_o  = !axi_areset_i &&
                          ((wr_state_reg == WR_IDLE) || (wr_state_reg == WR_HAVE_ADDR));
   assign axi_bvalid_o  = (wr_state_reg == WR_RESP);
   assign aw_fire       = axi_awvalid_i && axi_awready_o;
   assign w_fire        = axi_wvalid_i && axi_wready_o;

   always_ff @(posedge axi_aclk_i or posedge axi_areset_i) begin
      if (axi_areset_i) begin
         wr_state_reg <= WR_IDLE;
      end else begin
         wr_state_reg <= wr_state_next;
      end
   end

   always_comb begin
      wr_state_next = wr_state_reg;
      wr_commit     = 1'b0;
      case (wr_state_reg)
         WR_IDLE: begin
            if (aw_fire && w_fire) begin
               wr_state_next = WR_RESP;
               wr_commit     = 1'b1;
            end else if (aw_fire) begin
               wr_state_next = WR_HAVE_ADDR;
            end else if (w_fire) begin
               wr_state_next = WR_HAVE_DATA;
            end
         end
         WR_HAVE_ADDR: begin
            if (w_fire) begin
               wr_state_next = WR_RESP;
               wr_commit     = 1'b1;
            end
         end
         WR_HAVE_DATA: begin
            if (aw_fire) begin
               wr_state_next = WR_RESP;
               wr_commit     = 1'b1;
            end
         end
         WR_RESP: begin
            if (axi_bready_i) begin
               wr_state_next = WR_IDLE;
            end
         end
         default: wr_state_next = WR_IDLE;
      endcase
   end

   always_ff @(posedge axi_aclk_i or posedge axi_areset_i) begin
      if (axi_areset_i) begin
         aw_addr_reg <= '0;
         w_data_reg  <= '0;
         w_strb_reg  <= '0;
      end else begin
         if (aw_fire) aw_addr_reg <= axi_awaddr_i;
         if (w_fire) begin
            w_data_reg <= axi_wdata_i;
            w_strb_reg <= axi_wstrb_i;
         end
      end
   end

   // The half that is still arriving comes straight from the bus on the commit edge.
   assign wr_addr = (wr_state_reg == WR_HAVE_ADDR) ? aw_addr_reg : axi_awaddr_i;
   assign wr_data = (wr_state_reg == WR_HAVE_DATA) ? w_data_reg  : axi_wdata_i;
   assign wr_strb = (wr_state_reg == WR_HAVE_DATA) ? w_strb_reg  : axi_wstrb_i;
   assign wr_hit  = addr_hit(wr_addr);

   assign axi_arready_o = !axi_areset_i && !rvalid_reg;
   assign ar_fire       = axi_arvalid_i && axi_arready_o;
   assign rd_hit        = addr_hit(axi_araddr_i);

   axi_lite_reg_bank #(
      .NUM_REGS (NUM_REGS),
      .IDX_W    (IDX_W)
   ) u_reg_bank (
      .clk      (axi_aclk_i),
      .rst      (axi_areset_i),
      .we       (wr_commit && wr_hit),
      .wr_idx   (addr_idx(wr_addr)),
      .wr_strb  (wr_strb),
      .wr_data  (wr_data),
      .rd_idx   (addr_idx(axi_araddr_i)),
      .rd_data  (bank_rd_data),
      .reg_bank (reg_bank_o),
      .wr_pulse (wr_pulse_o)
   );

   // The bank updates with non-blocking writes, so a same-edge read captures the old value.
   always_ff @(posedge axi_aclk_i or posedge axi_areset_i) begin
      if (axi_areset_i) begin
         rvalid_reg <= 1'b0;
         rdata_reg  <= '0;
      end else if (ar_fire) begin
         rvalid_reg <= 1'b1;
         rdata_reg  <= rd_hit ? bank_rd_data : '0;
      end else if (rvalid_reg && axi_rready_i) begin
         rvalid_reg <= 1'b0;
      end
   end

   assign axi_rvalid_o = rvalid_reg;
   assign axi_rdata_o  = rdata_reg;

`ifdef AXI_SLV_DECERR_EN
   logic bresp_reg, rresp_reg;

   always_ff @(posedge axi_aclk_i or posedge axi_areset_i) begin
      if (axi_areset_i) begin
         bresp_reg <= RESP_OKAY;
         rresp_reg <= RESP_OKAY;
      end else begin
         if (wr_commit) bresp_reg <= wr_hit ? RESP_OKAY : RESP_SLVERR;
         if (ar_fire)   rresp_reg <= rd_hit ? RESP_OKAY : RESP_SLVERR;
      end
   end

   assign axi_bresp_o = bresp_reg;
   assign axi_rresp_o = rresp_reg;
`else
   assign axi_bresp_o = RESP_OKAY;
   assign axi_rresp_o = RESP_OKAY;
`endif

endmodule

// File: tb/tb_axi_lite_slave_regs.sv
// Self-checking bench for axi_lite_slave_regs: table-driven reads/writes with a
// response scoreboard, plus hand sequences for split AW/W, same-edge read/write and reset.
module tb_axi_lite_slave_regs;

   localparam int          NUM_REGS = 8;
   localparam logic [31:0] BASE     = 32'h2000_0000;
   localparam int          TMO      = 50;
`ifdef AXI_SLV_DECERR_EN
   localparam logic MISS_RESP = 1'b1;
`else
   localparam logic MISS_RESP = 1'b0;
`endif

   logic                   clk = 1'b0;
   logic                   areset;
   logic [31:0]            araddr;
   logic                   arvalid;
   logic                   arready;
   logic [31:0]            rdata;
   logic                   rresp;
   logic                   rvalid;
   logic                   rready;
   logic [31:0]            awaddr;
   logic                   awvalid;
   logic                   awready;
   logic [31:0]            wdata;
   logic [3:0]             wstrb;
   logic                   wvalid;
   logic                   wready;
   logic                   bresp;
   logic                   bvalid;
   logic                   bready;
   logic [NUM_REGS*32-1:0] reg_bank;
   logic [NUM_REGS-1:0]    wr_pulse;

   axi_lite_slave_regs #(
      .NUM_REGS  (NUM_REGS),
      .BASE_ADDR (BASE)
   ) dut (
      .axi_aclk_i    (clk),
      .axi_areset_i  (areset),
      .axi_araddr_i  (araddr),
      .axi_arvalid_i (arvalid),
      .axi_arready_o (arready),
      .axi_rdata_o   (rdata),
      .axi_rresp_o   (rresp),
      .axi_rvalid_o  (rvalid),
      .axi_rready_i  (rready),
      .axi_awaddr_i  (awaddr),
      .axi_awvalid_i (awvalid),
      .axi_awready_o (awready),
      .axi_wdata_i   (wdata),
      .axi_wstrb_i   (wstrb),
      .axi_wvalid_i  (wvalid),
      .axi_wready_o  (wready),
      .axi_bresp_o   (bresp),
      .axi_bvalid_o  (bvalid),
      .axi_bready_i  (bready),
      .reg_bank_o    (reg_bank),
      .wr_pulse_o    (wr_pulse)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          is_wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [31:0] exp_rdata;
      logic        exp_resp;
      int          hold;
   } vec_t;

   typedef struct {
      logic [31:0] data;
      logic        resp;
   } exp_t;

   vec_t        vecs [12];
   exp_t        sb_q [$];
   logic [31:0] model [NUM_REGS];
   int          checks = 0;
   int          errors = 0;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic model_hit(input logic [31:0] addr);
      return (addr >= BASE) && (((addr - BASE) >> 2) < NUM_REGS);
   endfunction

   function automatic logic [NUM_REGS*32-1:0] model_flat();
      logic [NUM_REGS*32-1:0] f;
      for (int i = 0; i < NUM_REGS; i++) f[32*i +: 32] = model[i];
      return f;
   endfunction

   task automatic wait_ready(input string name, ref logic sig);
      int n = 0;
      while (sig !== 1'b1 && n < TMO) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= TMO) check({name, "_timeout"}, 1'b0, 1'b1);
   endtask

   task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic exp_resp);
      exp_t e;
      int   idx;
      logic hit;
      sb_q.push_back('{data: 32'h0, resp: exp_resp});
      awaddr = addr; wdata = data; wstrb = strb;
      awvalid = 1'b1; wvalid = 1'b1;
      wait_ready("awready", awready);
      wait_ready("wready", wready);
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0;
      check("bvalid_after_commit", bvalid, 1'b1);
      e = sb_q.pop_front();
      check("bresp", bresp, e.resp);
      hit = model_hit(addr);
      idx = int'((addr - BASE) >> 2);
      if (hit) begin
         for (int b = 0; b < 4; b++)
            if (strb[b]) model[idx][8*b +: 8] = data[8*b +: 8];
      end
      check("wr_pulse", wr_pulse, hit ? (NUM_REGS'(1) << idx) : '0);
      check("reg_bank_after_write", reg_bank, model_flat());
      bready = 1'b1;
      @(posedge clk); #1;
      bready = 1'b0;
      check("bvalid_after_bready", bvalid, 1'b0);
      check("wr_pulse_one_cycle", wr_pulse, '0);
      $display("WRITE addr=%h data=%h strb=%h bresp=%0d", addr, data, strb, bresp);
   endtask

   task automatic do_read(input logic [31:0] addr, input logic [31:0] exp_data,
                          input logic exp_resp, input int hold);
      exp_t e;
      sb_q.push_back('{data: exp_data, resp: exp_resp});
      araddr = addr; arvalid = 1'b1;
      wait_ready("arready", arready);
      @(posedge clk); #1;
      arvalid = 1'b0;
      check("rvalid_after_ar", rvalid, 1'b1);
      e = sb_q.pop_front();
      check("rdata", rdata, e.data);
      check("rresp", rresp, e.resp);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         check("rdata_stable", {rvalid, rdata}, {1'b1, e.data});
         check("arready_busy", arready, 1'b0);
      end
      rready = 1'b1;
      @(posedge clk); #1;
      rready = 1'b0;
      check("rvalid_after_rready", rvalid, 1'b0);
      check("arready_back", arready, 1'b1);
      $display("READ  addr=%h rdata=%h rresp=%0d", addr, rdata, rresp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      areset = 1'b1;
      araddr = '0; arvalid = 1'b0; rready = 1'b0;
      awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
      for (int i = 0; i < NUM_REGS; i++) model[i] = '0;

      vecs[0]  = '{1'b1, 32'h2000_0008, 32'hDEAD_BEEF, 4'hF, 32'h0,          1'b0,      0};
      vecs[1]  = '{1'b0, 32'h2000_0008, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0,      0};
      vecs[2]  = '{1'b1, 32'h2000_0004, 32'h1234_5678, 4'hF, 32'h0,          1'b0,      0};
      vecs[3]  = '{1'b1, 32'h2000_0004, 32'h0000_AA00, 4'h2, 32'h0,          1'b0,      0};
      vecs[4]  = '{1'b0, 32'h2000_0004, 32'h0,         4'h0, 32'h1234_AA78, 1'b0,      4};
      vecs[5]  = '{1'b1, 32'h2000_001C, 32'hCAFE_F00D, 4'hF, 32'h0,          1'b0,      0};
      vecs[6]  = '{1'b0, 32'h2000_001F, 32'h0,         4'h0, 32'hCAFE_F00D, 1'b0,      0};
      vecs[7]  = '{1'b0, 32'h2000_0020, 32'h0,         4'h0, 32'h0,          MISS_RESP, 1};
      vecs[8]  = '{1'b1, 32'h1FFF_FFFC, 32'hFFFF_FFFF, 4'hF, 32'h0,          MISS_RESP, 0};
      vecs[9]  = '{1'b1, 32'h2000_0008, 32'h0,         4'h0, 32'h0,          1'b0,      0};
      vecs[10] = '{1'b0, 32'h2000_0008, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0,      0};
      vecs[11] = '{1'b0, 32'h2000_0000, 32'h0,         4'h0, 32'h0,          1'b0,      0};

      // Reset state
      #12;
      check("reset_readies", {awready, wready, arready}, 3'b000);
      check("reset_valids", {bvalid, rvalid, wr_pulse}, '0);
      @(posedge clk); #1;
      areset = 1'b0;
      #1;
      check("post_reset_readies", {awready, wready, arready}, 3'b111);
      check("post_reset_bank", reg_bank, '0);

      for (int v = 0; v < 12; v++) begin
         if (vecs[v].is_wr)
            do_write(vecs[v].addr, vecs[v].data, vecs[v].strb, vecs[v].exp_resp);
         else
            do_read(vecs[v].addr, vecs[v].exp_rdata, vecs[v].exp_resp, vecs[v].hold);
      end

      // W three cycles ahead of AW, reg0 preset to all ones
      do_write(BASE, 32'hFFFF_FFFF, 4'hF, 1'b0);
      wdata = 32'h1122_3344; wstrb = 4'h3; wvalid = 1'b1;
      wait_ready("wready_early", wready);
      @(posedge clk); #1;
      wvalid = 1'b0;
      check("wready_drop_after_w", wready, 1'b0);
      check("no_b_before_aw", bvalid, 1'b0);
      repeat (3) begin @(posedge clk); #1; end
      check("wready_held_low", {wready, awready, bvalid}, 3'b010);
      awaddr = BASE; awvalid = 1'b1;
      @(posedge clk); #1;
      awvalid = 1'b0;
      check("late_aw_bvalid", {bvalid, bresp}, 2'b10);
      check("late_aw_reg0", reg_bank[31:0], 32'hFFFF_3344);
      check("late_aw_pulse", wr_pulse, NUM_REGS'(1));
      bready = 1'b1; @(posedge clk); #1; bready = 1'b0;
      model[0] = 32'hFFFF_3344;
      $display("WRITE split W-then-AW reg0=%h", reg_bank[31:0]);

      // Same-edge read and write of reg2
      do_write(BASE + 32'h8, 32'h5, 4'hF, 1'b0);
      awaddr = BASE + 32'h8; wdata = 32'hA; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
      araddr = BASE + 32'h8; arvalid = 1'b1;
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      check("same_edge_valids", {bvalid, rvalid}, 2'b11);
      check("same_edge_old_data", rdata, 32'h5);
      check("same_edge_new_reg", reg_bank[95:64], 32'hA);
      bready = 1'b1; rready = 1'b1; @(posedge clk); #1; bready = 1'b0; rready = 1'b0;
      model[2] = 32'hA;
      $display("READ/WRITE same edge reg2 rdata=%h", rdata);
      do_read(BASE + 32'h8, 32'hA, 1'b0, 0);

      // Reset with a write response and read data both pending
      awaddr = BASE + 32'h4; wdata = 32'h7777_0000; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
      araddr = BASE + 32'h1C; arvalid = 1'b1;
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      check("pre_reset_pending", {bvalid, rvalid}, 2'b11);
      #2 areset = 1'b1;
      #1;
      check("reset_drops_valids", {bvalid, rvalid}, 2'b00);
      check("reset_forces_readies", {awready, wready, arready}, 3'b000);
      @(posedge clk); #1;
      areset = 1'b0;
      for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
      check("reset_clears_bank", reg_bank, '0);
      bready = 1'b1; rready = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
         check("no_stale_response", {bvalid, rvalid, wr_pulse}, '0);
      end
      bready = 1'b0; rready = 1'b0;
      $display("RESET mid-operation bvalid=%0d rvalid=%0d", bvalid, rvalid);
      do_read(BASE + 32'h1C, 32'h0, 1'b0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/axi_lite_slave_regs.md
Name: axi_lite_slave_regs

Overview:
AXI4-Lite responder (slave) presenting a bank of NUM_REGS 32-bit registers to the core-side AXI4-Lite master. It accepts write address and write data independently, applies byte strobes, and returns one write response per write. Reads return registered data. The register contents are exported in parallel to peripheral logic (GPIO/timer/UART control), together with per-register write pulses.

Parameters:
NUM_REGS, 8, number of 32-bit registers; legal range 1..64.
BASE_ADDR, 32'h2000_0000, byte address of register 0. Register i sits at BASE_ADDR + 4*i.

Ports:
axi_aclk_i  in  1  clock.
axi_areset_i  in  1  asynchronous reset, active-high.
axi_araddr_i  in  32  read address.
axi_arvalid_i  in  1  read address valid.
axi_arready_o  out  1  read address ready.
axi_rdata_o  out  32  read data.
axi_rresp_o  out  1  read response: 0 = OKAY, 1 = SLVERR.
axi_rvalid_o  out  1  read data valid.
axi_rready_i  in  1  read data ready.
axi_awaddr_i  in  32  write address.
axi_awvalid_i  in  1  write address valid.
axi_awready_o  out  1  write address ready.
axi_wdata_i  in  32  write data.
axi_wstrb_i  in  4  byte enables; bit n enables byte [8n+7:8n].
axi_wvalid_i  in  1  write data valid.
axi_wready_o  out  1  write data ready.
axi_bresp_o  out  1  write response: 0 = OKAY, 1 = SLVERR.
axi_bvalid_o  out  1  write response valid.
axi_bready_i  in  1  write response ready.
reg_bank_o  out  NUM_REGS*32  register contents; register i occupies bits [32i+31:32i].
wr_pulse_o  out  NUM_REGS  one-cycle pulse on the cycle after register i is written.

Behaviour:
- Reset (async, active-high): all registers, aw_hold, w_hold, bvalid, rvalid, rdata, rresp, bresp and wr_pulse are cleared to 0. While reset is asserted, all readies are forced to 0.
- Address decode:
  - off = addr - BASE_ADDR; idx = off[31:2]; addr[1:0] are ignored.
  - hit = (addr >= BASE_ADDR) && (idx < NUM_REGS).
- Write channel:
  - axi_awready_o = !aw_hold && !bvalid. axi_wready_o = !w_hold && !bvalid.
  - A handshake on AW latches awaddr and sets aw_hold. A handshake on W latches wdata/wstrb and sets w_hold.
  - Commit edge: the first edge at which both address and data are available, each either held or handshaking that cycle. AW and W may arrive in the same cycle or in either order.
  - At the commit edge:
    - if hit, update the strobed bytes of register idx and pulse wr_pulse_o[idx] in the next cycle;
    - if miss, no register changes;
    - set bvalid, set bresp (see Optional Feature), clear aw_hold and w_hold.
  - Latency: AW and W handshaking together at edge k gives bvalid high and the new register value visible from cycle k+1.
  - bvalid stays high with bresp stable until the bready handshake. No new AW or W is accepted while bvalid is high, so at most one write is outstanding.
  - wstrb = 0 still produces an OKAY response and a wr_pulse, with no data change.
- Read channel:
  - axi_arready_o = !rvalid.
  - On an AR handshake at edge k, rdata is registered at k and rvalid is high from k+1.
    - hit: rdata = register idx.
    - miss: rdata = 0.
  - rdata and rresp stay stable until the rready handshake. The next AR can be accepted in the cycle after rvalid drops.
- Simultaneous read and write:
  - The channels are independent; both may complete in the same cycle.
  - If the AR handshake and a write commit to the same register share an edge, the read returns the pre-write value.
- Reset mid-operation: any held AW/W, pending bvalid or pending rvalid is discarded immediately. No response is issued after reset.
- There are no combinational paths from inputs to valids. Readies depend only on internal state.

Optional Feature:
- Macro: AXI_SLV_DECERR_EN.
- Defined: a miss returns resp = 1 (SLVERR) on both B and R; read data is 0 and the write is dropped.
- Undefined: a miss returns resp = 0 (OKAY), the write is silently dropped and the read returns 0. The resp outputs are then constant 0.

Decomposition:
- Shared header axi_lite_defs.vh holds:
  - RESP_OKAY = 1'b0 and RESP_SLVERR = 1'b1;
  - AXI_ADDR_W = 32, AXI_DATA_W = 32, AXI_STRB_W = 4.
  - The core-side master includes the same header.
- Sub-module axi_lite_reg_bank: register storage only. Inputs are write enable, index, strobe and data; outputs are the flat bank and wr_pulse; it has an asynchronous read port. The protocol FSMs stay in the top module.

Test Plan:
- AW 0x2000_0008 and W 0xDEAD_BEEF with strb 0xF in the same cycle, bready=1 → bvalid at +1, bresp=0, reg_bank_o[95:64]=0xDEADBEEF, wr_pulse_o=8'b0000_0100 for one cycle.
- W (0x1122_3344, strb 0x3) three cycles before AW 0x2000_0000, with reg0 preset to 0xFFFF_FFFF → wready drops after the W handshake, commit follows the AW handshake, reg0=0xFFFF_3344.
- AR 0x2000_0004 with rready held 0 for 4 cycles → rvalid high from +1, rdata stable at reg1, arready=0 throughout. After rready=1, arready returns to 1 the next cycle.
- AR 0x2000_0020 (idx 8, miss) → rdata=0; rresp=1 with AXI_SLV_DECERR_EN, 0 without. An AW/W to 0x1FFF_FFFC leaves all registers unchanged and gives bresp following the same rule.
- Same-edge AR and write commit to reg2 (old value 0x5, new value 0xA) → rdata=0x5; a subsequent read returns 0xA.
- axi_areset_i asserted while bvalid=1 and rvalid=1 → both drop immediately, all registers read 0 after release, and no stale B or R response appears.
